// File: rtl/bf_pkg.sv
// bf_pkg: op codes and tape FSM states shared by the BF data-tape unit
package bf_pkg;
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PTR_INC = 3'd1,
    OP_PTR_DEC = 3'd2,
    OP_VAL_INC = 3'd3,
    OP_VAL_DEC = 3'd4,
    OP_VAL_WR  = 3'd5,
    OP_CLEAR   = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;
  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD
  } tape_state_e;
endpackage

// File: rtl/bf_tape_ram.sv
// bf_tape_ram: single-port synchronous-read tape storage, write-first, no reset
module bf_tape_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // a write also forwards its data to the read port
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
      q <= wdata;
    end else q <= mem[addr];
  end
endmodule

// File: rtl/bf_tape.sv
// bf_tape: BF data tape with pointer, cell register, clear sweep and load stall
module bf_tape
  import bf_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter bit PTR_WRAP = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op_data,
  output logic              op_ready,
  output logic [DATA_W-1:0] cell_q,
  output logic              cell_zero,
  output logic [ADDR_W-1:0] ptr,
  output logic              busy,
  output logic              ptr_err
);
  localparam int DEPTH = 2**ADDR_W;
  tape_state_e state, state_next;
  op_e op_c;
  logic [ADDR_W-1:0] sweep_addr, ptr_next, ram_addr;
  logic [DATA_W-1:0] cell_next, ram_wdata, ram_q;
  logic accept, is_move, is_val, at_edge, move, sat, val_wr, clr, ram_we, sweep_done;
  assign op_c = op_e'(op);
  assign cell_zero = cell_q == '0;
  assign sweep_done = sweep_addr == ADDR_W'(DEPTH - 1);
  // state register
  always_ff @(posedge clock) state <= state_next;
  // op decode, next state and RAM port steering (sweep owns the port while clearing)
  always_comb begin
    op_ready = state == ST_IDLE;
    busy = state == ST_CLEAR;
    accept = op_ready && op_valid && !reset;
    is_move = op_c == OP_PTR_INC || op_c == OP_PTR_DEC;
    is_val = op_c == OP_VAL_INC || op_c == OP_VAL_DEC || op_c == OP_VAL_WR;
    at_edge = op_c == OP_PTR_INC ? ptr == '1 : ptr == '0;
    move = accept && is_move && (PTR_WRAP || !at_edge);
    sat = accept && is_move && !PTR_WRAP && at_edge;
    val_wr = accept && is_val;
    clr = reset || (accept && op_c == OP_CLEAR);
    ptr_next = op_c == OP_PTR_INC ? ptr + ADDR_W'(1) : ptr - ADDR_W'(1);
    cell_next = op_c == OP_VAL_INC ? cell_q + DATA_W'(1) :
                op_c == OP_VAL_DEC ? cell_q - DATA_W'(1) : op_data;
    ram_we = busy || val_wr;
    ram_addr = busy ? sweep_addr : move ? ptr_next : ptr;
    ram_wdata = busy ? '0 : cell_next;
    state_next = clr ? ST_CLEAR :
                 busy ? (sweep_done ? ST_IDLE : ST_CLEAR) :
                 move ? ST_LOAD : ST_IDLE;
  end
  // pointer, cell register, sweep counter and sticky error
  always_ff @(posedge clock) begin
    if (clr) begin
      sweep_addr <= '0;
      ptr <= '0;
      cell_q <= '0;
      ptr_err <= 1'b0;
    end else begin
      if (busy) sweep_addr <= sweep_addr + ADDR_W'(1);
      if (move) ptr <= ptr_next;
      if (sat) ptr_err <= 1'b1;
      if (val_wr) cell_q <= cell_next;
      else if (state == ST_LOAD) cell_q <= ram_q;
    end
  end
  bf_tape_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clock(clock),
    .we(ram_we),
    .addr(ram_addr),
    .wdata(ram_wdata),
    .q(ram_q)
  );
endmodule

// File: doc/bf_tape.md
Name: bf_tape

Overview:
Parametrised data-tape unit for the BF machine. It holds the data pointer and the current-cell register, and executes pointer and cell operations in response to decoded ops from the control unit. Storage is a single-port synchronous-read RAM. Clearing is a sequential sweep, one cell per cycle, with a busy indication. The control unit sees the current cell value and a zero flag for loop decisions.

Parameters:
DATA_W, 8, cell width in bits; all cell arithmetic is modulo 2**DATA_W.
ADDR_W, 8, pointer width; DEPTH = 2**ADDR_W is a derived localparam and is not overridable.
PTR_WRAP, 1, 1 = the pointer wraps modulo DEPTH; 0 = the pointer saturates at 0 and DEPTH-1 and raises ptr_err.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high; starts a clear sweep.
op_valid  in  1  op request.
op  in  3  op code (see Behaviour).
op_data  in  DATA_W  value for VAL_WR (the ',' input byte).
op_ready  out  1  high when an op can be accepted this cycle.
cell_q  out  DATA_W  value of the cell at ptr.
cell_zero  out  1  cell_q == 0, combinational from the cell register.
ptr  out  ADDR_W  current data pointer.
busy  out  1  high during a clear sweep.
ptr_err  out  1  sticky pointer-saturation flag (PTR_WRAP=0 only).

Behaviour:
- Op codes: 0 NOP, 1 PTR_INC, 2 PTR_DEC, 3 VAL_INC, 4 VAL_DEC, 5 VAL_WR, 6 CLEAR, 7 reserved (acts as NOP).
- An op is accepted on a rising edge where op_valid && op_ready. The value of op while op_ready=0 is ignored.
- FSM states:
  - CLEAR: op_ready=0, busy=1. Writes 0 to address sweep_addr each cycle; sweep_addr counts 0..DEPTH-1. After writing DEPTH-1 the FSM moves to IDLE. The sweep lasts exactly DEPTH cycles.
  - IDLE: op_ready=1, busy=0.
  - LOAD: op_ready=0. The RAM read of the new ptr (issued on the move edge) returns; cell_q is captured from it; the FSM goes to IDLE on the next edge. A pointer move therefore makes op_ready low for exactly 1 cycle.
- Reset (any state, including mid-sweep or LOAD):
  - Next cycle: FSM=CLEAR, sweep_addr=0, ptr=0, cell_q=0, cell_zero=1, ptr_err=0, op_ready=0, busy=1.
  - Reset asserted mid-sweep restarts the sweep from 0.
- CLEAR op: same effect as reset, including clearing ptr_err.
- VAL_INC / VAL_DEC / VAL_WR:
  - The cell register is updated to cell+1, cell-1 or op_data, and the same value is written to RAM[ptr] on the accepting edge.
  - cell_q shows the new value on the next cycle. op_ready stays high, so one op per cycle is possible.
  - Wrap: 0xFF+1 gives 0x00; 0x00-1 gives 0xFF (for DATA_W=8).
- PTR_INC / PTR_DEC:
  - ptr is updated and a RAM read is issued at the new ptr; FSM goes to LOAD. During LOAD, cell_q holds its old value.
  - With PTR_WRAP=1: DEPTH-1 +1 gives 0; 0 -1 gives DEPTH-1.
  - With PTR_WRAP=0, a move past either end leaves ptr unchanged, sets ptr_err=1, does not enter LOAD, and keeps op_ready=1.
- The RAM has no reset; its contents are defined only by the clear sweep.
- Outputs are registered, except cell_zero.

Decomposition:
- Package bf_pkg: the op_e enum (3-bit, codes above) and the tape_state_e enum (CLEAR, IDLE, LOAD).
- Sub-module bf_tape_ram: single-port RAM, DEPTH x DATA_W, synchronous read, write-first on a same-address write, no reset. Parameters are DATA_W and ADDR_W.
- bf_tape contains the FSM, the sweep counter, the pointer/cell logic and the write-address mux (sweep_addr vs ptr).

Test Plan:
- Reset pulse for 1 cycle -> busy=1 and op_ready=0 for exactly 256 cycles, then op_ready=1, ptr=0, cell_q=0, cell_zero=1. Then 255 PTR_INC ops -> every cell_q after its LOAD reads 0.
- VAL_WR 0x41 at ptr 0, PTR_INC, VAL_INC x3, PTR_DEC -> after the LOAD, cell_q=0x41. Then PTR_INC -> cell_q=0x03.
- PTR_WRAP=1: PTR_DEC at ptr 0 -> ptr=255, op_ready low 1 cycle. VAL_DEC -> cell_q=0xFF, cell_zero=0. VAL_INC -> cell_q=0x00, cell_zero=1.
- PTR_WRAP=0: PTR_DEC at ptr 0 -> ptr=0, ptr_err=1, op_ready stays 1. Then CLEAR op -> ptr_err=0 next cycle, busy=1 for 256 cycles.
- Back-to-back VAL_INC with op_valid held high for 300 cycles -> cell_q counts 1..255, 0, 1..44 with no stall.
- Write 0x55 to cells 0-9, issue CLEAR, assert reset at sweep cycle 5 -> sweep restarts from 0, busy stays high 256 cycles after reset, and all cells 0-9 then read 0.
